// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC frame scheduler.
// Used by dac_frame_scheduler and dac_ch_holding.
package dac_pkg;

    localparam int DAC_W      = 12;
    // 16 serial bits, the go cycle and the cycle the serializer needs to return ready
    localparam int MIN_PERIOD = 18;

    localparam logic [DAC_W-1:0] DAC_MIDSCALE = 12'h800;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/dac_ch_holding.sv
// One-entry valid/ready holding register for a DAC channel, with a record
// of the last sample actually issued to the serializer.
module dac_ch_holding
    import dac_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [DAC_W-1:0] data,
    input  logic             consume,
    output logic             ready,
    output logic             full,
    output logic [DAC_W-1:0] held,
    output logic [DAC_W-1:0] last
);

    logic             full_r;
    logic [DAC_W-1:0] held_r;
    logic [DAC_W-1:0] last_r;
    logic             ready_s;
    logic             load_s;

    // Accept when empty or when the entry is being drained this cycle
    always_comb begin
        ready_s = !full_r || consume;
        load_s  = valid && ready_s;
    end

    // Entry storage: a same-cycle load wins over the consume
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_r <= 1'b0;
            held_r <= 12'h000;
        end else if (load_s) begin
            full_r <= 1'b1;
            held_r <= data;
        end else if (consume) begin
            full_r <= 1'b0;
        end
    end

    // Only real producer samples become the last issued value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r <= 12'h000;
        end else if (consume && full_r) begin
            last_r <= held_r;
        end
    end

    // Output mapping
    always_comb begin
        ready = ready_s;
        full  = full_r;
        held  = held_r;
        last  = last_r;
    end

endmodule

// File: rtl/dac_frame_scheduler.sv
// Paces dual-channel sample frames to the DAC serializer at a programmable period.
// Build option DAC_MIDSCALE_UNDERRUN_EN: underruns send midscale instead of repeating the last sample.
module dac_frame_scheduler
    import dac_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic                ch1_valid,
    input  logic [DAC_W-1:0]    ch1_data,
    output logic                ch1_ready,
    input  logic                ch2_valid,
    input  logic [DAC_W-1:0]    ch2_data,
    output logic                ch2_ready,
    input  logic                dac_ready,
    output logic                dac_go,
    output logic [DAC_W-1:0]    dac_data1,
    output logic [DAC_W-1:0]    dac_data2,
    output logic                busy,
    output logic                overrun,
    output logic [CNT_W-1:0]    ch1_underruns,
    output logic [CNT_W-1:0]    ch2_underruns
);

    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    sched_state_t        state_r;
    sched_state_t        state_s;
    logic [PERIOD_W-1:0] eff_s;
    logic [PERIOD_W-1:0] count_r;
    logic [PERIOD_W-1:0] count_eff_s;
    logic                run_r;
    logic                tick_s;
    logic                go_s;
    logic                overrun_r;
    logic [CNT_W-1:0]    und1_r;
    logic [CNT_W-1:0]    und2_r;
    logic [DAC_W-1:0]    data1_r;
    logic [DAC_W-1:0]    data2_r;
    logic [DAC_W-1:0]    mux1_s;
    logic [DAC_W-1:0]    mux2_s;
    logic [DAC_W-1:0]    sub1_s;
    logic [DAC_W-1:0]    sub2_s;
    logic                full1_s;
    logic                full2_s;
    logic [DAC_W-1:0]    held1_s;
    logic [DAC_W-1:0]    held2_s;
    logic [DAC_W-1:0]    last1_s;
    logic [DAC_W-1:0]    last2_s;

    dac_ch_holding u_ch1 (
        .clk     (clk),
        .rst     (rst),
        .valid   (ch1_valid),
        .data    (ch1_data),
        .consume (go_s),
        .ready   (ch1_ready),
        .full    (full1_s),
        .held    (held1_s),
        .last    (last1_s)
    );

    dac_ch_holding u_ch2 (
        .clk     (clk),
        .rst     (rst),
        .valid   (ch2_valid),
        .data    (ch2_data),
        .consume (go_s),
        .ready   (ch2_ready),
        .full    (full2_s),
        .held    (held2_s),
        .last    (last2_s)
    );

    // Effective period and tick; the first enabled cycle behaves as a fresh reload
    always_comb begin
        eff_s       = (period < MIN_P) ? MIN_P : period;
        count_eff_s = run_r ? count_r : (eff_s - PERIOD_W'(1));
        tick_s      = enable && (count_eff_s == {PERIOD_W{1'b0}});
    end

    // Pacing down-counter; a new period is only picked up at reload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {PERIOD_W{1'b0}};
            run_r   <= 1'b0;
        end else if (!enable) begin
            count_r <= eff_s - PERIOD_W'(1);
            run_r   <= 1'b0;
        end else if (tick_s) begin
            count_r <= eff_s - PERIOD_W'(1);
            run_r   <= 1'b1;
        end else begin
            count_r <= count_eff_s - PERIOD_W'(1);
            run_r   <= 1'b1;
        end
    end

    // Frame FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Frame FSM next state and go strobe
    always_comb begin
        state_s = state_r;
        go_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (tick_s) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (dac_ready) begin
                    go_s    = 1'b1;
                    state_s = BUSY;
                end else begin
                    state_s = ISSUE;
                end
            end
            BUSY: begin
                if (dac_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = BUSY;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Substitute sample for a channel whose producer missed the slot
    always_comb begin
`ifdef DAC_MIDSCALE_UNDERRUN_EN
        sub1_s = DAC_MIDSCALE;
        sub2_s = DAC_MIDSCALE;
`else
        sub1_s = last1_s;
        sub2_s = last2_s;
`endif
        mux1_s = full1_s ? held1_s : sub1_s;
        mux2_s = full2_s ? held2_s : sub2_s;
    end

    // Frame sample registers, held between frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data1_r <= 12'h000;
            data2_r <= 12'h000;
        end else if (go_s) begin
            data1_r <= mux1_s;
            data2_r <= mux2_s;
        end
    end

    // Underrun counters and sticky overrun flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            und1_r    <= {CNT_W{1'b0}};
            und2_r    <= {CNT_W{1'b0}};
            overrun_r <= 1'b0;
        end else begin
            if (go_s && !full1_s) begin
                und1_r <= sat_inc(und1_r);
            end
            if (go_s && !full2_s) begin
                und2_r <= sat_inc(und2_r);
            end
            if (tick_s && (state_r != IDLE)) begin
                overrun_r <= 1'b1;
            end
        end
    end

    // Samples are presented in the go cycle itself and held afterwards
    always_comb begin
        dac_go        = go_s;
        busy          = (state_r == BUSY);
        overrun       = overrun_r;
        ch1_underruns = und1_r;
        ch2_underruns = und2_r;
        if (go_s) begin
            dac_data1 = mux1_s;
            dac_data2 = mux2_s;
        end else begin
            dac_data1 = data1_r;
            dac_data2 = data2_r;
        end
    end

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Self-checking bench for dac_frame_scheduler: event-level reference model plus directed phases.
module tb_dac_frame_scheduler;
    import dac_pkg::*;

    localparam int PW = 16;
    localparam int CW = 4;
`ifdef DAC_MIDSCALE_UNDERRUN_EN
    localparam logic [11:0] SUB_LIT = 12'h800;
`else
    localparam logic [11:0] SUB_LIT = 12'h3A5;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [PW-1:0] period;
    logic          ch1_valid, ch2_valid, ch1_ready, ch2_ready;
    logic [11:0]   ch1_data, ch2_data, dac_data1, dac_data2;
    logic          dac_ready, dac_go, busy, overrun;
    logic [CW-1:0] ch1_underruns, ch2_underruns;

    dac_frame_scheduler #(.PERIOD_W(PW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .period(period),
        .ch1_valid(ch1_valid), .ch1_data(ch1_data), .ch1_ready(ch1_ready),
        .ch2_valid(ch2_valid), .ch2_data(ch2_data), .ch2_ready(ch2_ready),
        .dac_ready(dac_ready), .dac_go(dac_go), .dac_data1(dac_data1), .dac_data2(dac_data2),
        .busy(busy), .overrun(overrun),
        .ch1_underruns(ch1_underruns), .ch2_underruns(ch2_underruns)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: absolute tick times, pending/in-flight frame flags
    int          cyc = 0;
    bit          m_run, m_req, m_fly, m_ovr;
    int          m_next_tick;
    bit          m_full[2];
    logic [11:0] m_val[2], m_last[2], m_out[2];
    int          m_und[2];

    // stimulus state
    int          ser_cnt = 0;
    int          stall_len = 15;
    bit          ch_off[2];
    logic [11:0] ch_next[2];
    int          stage = 0;
    bit          arm_3a5 = 1'b1;
    bit          und_pending = 1'b0;
    bit          pin_first = 1'b1;
    bit          first_go_pending = 1'b0;
    int          rel_cyc = 0;
    int          last_go = 0;
    int          exp_spacing = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_req = 1'b0; m_fly = 1'b0; m_ovr = 1'b0; m_next_tick = 0;
        last_go = 0;
        for (int i = 0; i < 2; i++) begin
            m_full[i] = 1'b0; m_val[i] = 12'h000; m_last[i] = 12'h000;
            m_out[i] = 12'h000; m_und[i] = 0;
        end
    endtask

    task automatic model_check();
        int          eff;
        bit          tick, go, nreq, nfly;
        bit          rdy[2], xfer[2], vin[2];
        logic [11:0] exp_d[2], din[2], sub;
        cyc++;
        if (rst) begin
            chk("rst_go", dac_go, 0);
            chk("rst_busy", busy, 0);
            chk("rst_overrun", overrun, 0);
            chk("rst_und1", ch1_underruns, 0);
            chk("rst_und2", ch2_underruns, 0);
            chk("rst_data1", dac_data1, 0);
            chk("rst_data2", dac_data2, 0);
            model_reset();
            ser_cnt = 0;
            return;
        end
        vin[0] = ch1_valid; vin[1] = ch2_valid;
        din[0] = ch1_data;  din[1] = ch2_data;
        eff = (int'(period) < MIN_PERIOD) ? MIN_PERIOD : int'(period);
        if (enable && !m_run) m_next_tick = cyc + eff - 1;
        tick = enable && (cyc == m_next_tick);
        go   = m_req && dac_ready;
        for (int i = 0; i < 2; i++) begin
            rdy[i] = !m_full[i] || go;
`ifdef DAC_MIDSCALE_UNDERRUN_EN
            sub = 12'h800;
`else
            sub = m_last[i];
`endif
            exp_d[i] = go ? (m_full[i] ? m_val[i] : sub) : m_out[i];
            xfer[i]  = vin[i] && rdy[i];
        end
        chk("dac_go", dac_go, go);
        chk("busy", busy, m_fly);
        chk("overrun", overrun, m_ovr);
        chk("ch1_ready", ch1_ready, rdy[0]);
        chk("ch2_ready", ch2_ready, rdy[1]);
        chk("dac_data1", dac_data1, exp_d[0]);
        chk("dac_data2", dac_data2, exp_d[1]);
        chk("ch1_underruns", ch1_underruns, m_und[0]);
        chk("ch2_underruns", ch2_underruns, m_und[1]);

        if (und_pending) begin
            chk("ch2_underrun_count", ch2_underruns, 1);
            chk("ch1_no_underrun", ch1_underruns, 0);
            und_pending = 1'b0;
        end
        if (go) begin
            if (pin_first) begin
                chk("first_go_data1", dac_data1, 12'h100);
                chk("first_go_data2", dac_data2, 12'h3A0);
                pin_first = 1'b0;
            end
            if (exp_spacing != 0 && last_go > 0) chk("go_spacing", cyc - last_go, exp_spacing);
            last_go = cyc;
            if (first_go_pending) begin
                chk("first_go_after_reset", cyc - rel_cyc, 20);
                first_go_pending = 1'b0;
            end
            if (stage == 2) begin
                chk("underrun_substitute", dac_data2, SUB_LIT);
                stage = 0;
                und_pending = 1'b1;
            end else if (stage == 1) begin
                chk("issued_3a5", dac_data2, 12'h3A5);
                stage = 2;
            end
        end

        if (tick) begin
            m_next_tick = cyc + eff;
            if (m_req || m_fly) m_ovr = 1'b1;
        end
        nreq = m_req ? !dac_ready : (tick && !m_fly);
        nfly = m_fly ? !dac_ready : go;
        m_req = nreq;
        m_fly = nfly;
        for (int i = 0; i < 2; i++) begin
            if (go) begin
                if (m_full[i]) m_last[i] = m_val[i];
                else if (m_und[i] < (1 << CW) - 1) m_und[i]++;
                m_out[i] = exp_d[i];
            end
            if (xfer[i]) begin
                m_full[i] = 1'b1;
                m_val[i]  = din[i];
                ch_next[i] = ch_next[i] + 12'h001;
            end else if (go) begin
                m_full[i] = 1'b0;
            end
        end
        if (xfer[1] && arm_3a5 && din[1] == 12'h3A5) begin
            stage = 1;
            arm_3a5 = 1'b0;
        end
        m_run = enable;
        if (go) ser_cnt = stall_len;
    endtask

    task automatic drive();
        if (ser_cnt > 0) begin
            dac_ready = 1'b0;
            ser_cnt--;
        end else begin
            dac_ready = 1'b1;
        end
        ch1_valid = !ch_off[0];
        ch1_data  = ch_next[0];
        ch2_valid = !ch_off[1] && (stage == 0);
        ch2_data  = ch_next[1];
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_busy();
        int k;
        k = 0;
        while (busy !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        chk("busy_reached", busy, 1);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; period = 16'd40;
        ch_off[0] = 1'b0; ch_off[1] = 1'b0;
        ch_next[0] = 12'h100; ch_next[1] = 12'h3A0;
        model_reset();
        drive();
        run(3);

        // nominal pacing at period 40, including the ch2 missed slot
        rst = 1'b0; enable = 1'b1; exp_spacing = 40;
        run(400);

        // short period is clamped to the minimum
        exp_spacing = 0; period = 16'd5;
        run(60);
        exp_spacing = 18;
        run(18 * 6);
        chk("no_overrun_min_period", overrun, 0);

        // slow serializer: ticks land while busy
        exp_spacing = 0; period = 16'd20; stall_len = 30;
        run(60);
        exp_spacing = 40;
        run(160);
        chk("overrun_sticky", overrun, 1);

        // serializer not ready when a tick arrives
        exp_spacing = 0; stall_len = 15; period = 16'd18;
        ser_cnt = 25;
        run(80);

        // enable dropped mid-frame
        wait_busy();
        enable = 1'b0;
        run(40);
        chk("idle_after_disable", busy, 0);
        enable = 1'b1;
        run(40);

        // ch1 starved long enough to saturate its counter
        ch_off[0] = 1'b1;
        run(18 * 22);
        chk("und1_saturated", ch1_underruns, 4'hF);
        ch_off[0] = 1'b0;
        run(20);

        // asynchronous reset during a frame
        period = 16'd20;
        wait_busy();
        rst = 1'b1;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_go", dac_go, 0);
        chk("async_rst_und1", ch1_underruns, 0);
        run(2);
        rst = 1'b0;
        rel_cyc = cyc + 1;
        first_go_pending = 1'b1;
        run(60);
        chk("first_go_seen_after_reset", first_go_pending, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_frame_scheduler.md
Name: dac_frame_scheduler

Overview:
Paces sample delivery to the dual-channel DAC serializer at a programmable sample period. Buffers one pending 12-bit sample per channel from two valid/ready producers (e.g. sin LUT readers). Issues one `go` per period and waits out the 16-cycle serial frame. Counts per-channel underruns when a producer misses its slot.

Parameters:
- PERIOD_W, 16, width of sample-period config (clk cycles per frame).
- CNT_W, 16, width of saturating underrun counters.

Ports:
- clk, in, 1, system clock (same clock drives the DAC serializer).
- rst, in, 1, asynchronous active-high reset.
- enable, in, 1, run sample pacing.
- period, in, PERIOD_W, clk cycles between frame starts; values below MIN_PERIOD are treated as MIN_PERIOD.
- ch1_valid / ch2_valid, in, 1, producer sample valid.
- ch1_data / ch2_data, in, 12, producer sample.
- ch1_ready / ch2_ready, out, 1, holding register can accept.
- dac_ready, in, 1, serializer idle/ready.
- dac_go, out, 1, one-cycle frame start to serializer.
- dac_data1 / dac_data2, out, 12, frame samples; stable from the go cycle.
- busy, out, 1, frame in flight.
- overrun, out, 1, sticky: tick arrived while frame in flight.
- ch1_underruns / ch2_underruns, out, CNT_W, saturating underrun counts.

Behaviour:
- Reset (async): all outputs 0, counters 0, holding regs empty, last-sample regs 12'h000, period counter 0, state IDLE.
- Holding reg per channel:
  - `chN_ready = !full | consume`.
  - A transfer (valid & ready) loads data and sets full.
  - Consume at issue clears full unless a same-cycle load refills it.
- Pacing counter:
  - While enable, counts down from eff_period-1, where eff_period = max(period, MIN_PERIOD = 18).
  - Tick when count==0, then reload. Period changes take effect at next reload.
  - enable=0: counter held at eff_period-1.
- FSM states: IDLE, ISSUE, BUSY.
  - IDLE: on tick go to ISSUE.
  - ISSUE:
    - Wait for dac_ready=1.
    - In that cycle pulse dac_go and drive dac_dataN = full ? held value : substitute. Substitute is last issued value, or see optional feature.
    - Consume full channels; update last-sample regs.
    - Increment chN_underruns for each empty channel, saturating at all-ones.
    - Then go to BUSY.
  - BUSY:
    - busy=1. Return to IDLE on first cycle dac_ready=1.
    - dac_ready is 0 from the cycle after go, so there is no false exit.
- dac_dataN registered and held between frames.
- A tick in ISSUE or BUSY sets overrun (sticky until rst) and is dropped.
- enable deasserted mid-frame: current frame completes, FSM returns to IDLE, no new ticks; holding regs retained.
- Producer load and consume on the same channel in the same cycle: new data held, full stays 1.
- Frame latency: tick to dac_go is 1 cycle when serializer is ready.

Optional Feature:
- DAC_MIDSCALE_UNDERRUN_EN defined: underrun substitute is 12'h800 (midscale, zero output); last-sample regs are not updated by substitutes.
- Undefined: substitute is the channel's last issued sample (hold).

Decomposition:
- dac_pkg holds:
  - DAC_W=12.
  - MIN_PERIOD=18 (16 bits + go + return cycle).
  - DAC_MIDSCALE=12'h800.
  - sched_state_t enum {IDLE, ISSUE, BUSY}.
- Sub-module dac_ch_holding: one-entry valid/ready holding register with consume input, full output and last-value register; instantiated twice.

Test Plan:
- period=40, both producers always valid, serializer model (ready drops 16 cycles after go) -> dac_go exactly every 40 cycles; data matches producer order; underruns stay 0; overrun 0.
- period=5 -> effective 18; go spacing 18 cycles; no overrun.
- ch2 valid withheld for one slot after issuing 12'h3A5 -> that frame dac_data2=12'h3A5 (12'h800 with macro); ch2_underruns=1; ch1 unaffected.
- Serializer model holds dac_ready=0 for 30 cycles with period=20 -> overrun=1; dac_go delayed until ready; no double go.
- Preset underrun counter near max with CNT_W=4, 20 empty slots -> counter saturates at 4'hF.
- Assert rst mid-BUSY -> dac_go/busy/counters 0 immediately (async); after release, first go one eff_period later.
